vga_timing_gen: RTL and testbench

- Upstream and downstream neighbour of display_control in the Tetris VGA path.
- Generates the 640x480@60 Hz raster from clk_25MHz: pixel_x, pixel_y and video_on drive display_control's pixel inputs.
- Registers display_control's combinational pixel_rgb together with delayed sync pulses, so colour and sync reach the VGA pins aligned.
- Provides a once-per-frame vblank_tick and a frame counter that the game logic uses to pace gravity and update the board safely.

---
 rtl/vga_timing_gen.sv | 95 +++++++++
 tb/tb_vga_timing_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster generator: pixel counters, registered sync/colour aligned one clock
// behind pixel_x/pixel_y, and a once-per-frame vblank tick with a wrapping frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic [11:0] pixel_rgb,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic [11:0] vga_rgb,
  output logic        vblank_tick,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HVis     = 10'(H_VISIBLE);
  localparam logic [9:0] VVis     = 10'(V_VISIBLE);
  localparam logic [9:0] VVisLast = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HsFirst  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HsLast   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VsFirst  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VsLast   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        hsync_n_q, hsync_n_d;
  logic        vsync_n_q, vsync_n_d;
  logic [11:0] vga_rgb_q, vga_rgb_d;
  logic        vblank_tick_q, vblank_tick_d;
  logic [7:0]  frame_cnt_q;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == VLast) ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    video_on      = (h_cnt_q < HVis) && (v_cnt_q < VVis) && !rst;
    hsync_n_d     = !((h_cnt_q >= HsFirst) && (h_cnt_q <= HsLast));
    vsync_n_d     = !((v_cnt_q >= VsFirst) && (v_cnt_q <= VsLast));
    vga_rgb_d     = video_on ? pixel_rgb : 12'h000;
    // Fires only on the last-visible-line wrap, never on the end-of-frame wrap.
    vblank_tick_d = (h_cnt_q == HLast) && (v_cnt_q == VVisLast);
  end

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      vga_rgb_q     <= 12'h000;
      vblank_tick_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      vga_rgb_q     <= vga_rgb_d;
      vblank_tick_q <= vblank_tick_d;
      if (vblank_tick_d) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign vga_rgb     = vga_rgb_q;
  assign vblank_tick = vblank_tick_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a shrunken-timing instance, both checked
// every cycle against an arithmetic raster model derived from elapsed clocks since reset.
module tb_vga_timing_gen;

  localparam int BHV = 8, BHFP = 2, BHS = 3, BHBP = 2;
  localparam int BVV = 6, BVFP = 1, BVS = 2, BVBP = 2;
  localparam int BHT = BHV + BHFP + BHS + BHBP;
  localparam int BVT = BVV + BVFP + BVS + BVBP;
  localparam int BF  = BHT * BVT;
  localparam int PH2 = 42400;
  localparam logic [43:0] RstVec = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'd0, 1'b0, 8'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] rgb_a = 12'h000;
  logic [11:0] rgb_b = 12'h000;

  logic [9:0]  pixel_x_a, pixel_y_a, pixel_x_b, pixel_y_b;
  logic        video_on_a, hsync_n_a, vsync_n_a, vblank_tick_a;
  logic        video_on_b, hsync_n_b, vsync_n_b, vblank_tick_b;
  logic [11:0] vga_rgb_a, vga_rgb_b;
  logic [7:0]  frame_cnt_a, frame_cnt_b;

  int     n_checks = 0;
  int     n_errors = 0;
  longint t = 0;
  int     hs_low = 0, hs_first = -1, vs_low = 0, ticks_first = 0, tick_first_t = -1;
  int     ticks_b = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk_25MHz  (clk),
    .rst        (rst),
    .pixel_rgb  (rgb_a),
    .pixel_x    (pixel_x_a),
    .pixel_y    (pixel_y_a),
    .video_on   (video_on_a),
    .hsync_n    (hsync_n_a),
    .vsync_n    (vsync_n_a),
    .vga_rgb    (vga_rgb_a),
    .vblank_tick(vblank_tick_a),
    .frame_cnt  (frame_cnt_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(BHV), .H_FP(BHFP), .H_SYNC(BHS), .H_BP(BHBP),
    .V_VISIBLE(BVV), .V_FP(BVFP), .V_SYNC(BVS), .V_BP(BVBP)
  ) u_dut_b (
    .clk_25MHz  (clk),
    .rst        (rst),
    .pixel_rgb  (rgb_b),
    .pixel_x    (pixel_x_b),
    .pixel_y    (pixel_y_b),
    .video_on   (video_on_b),
    .hsync_n    (hsync_n_b),
    .vsync_n    (vsync_n_b),
    .vga_rgb    (vga_rgb_b),
    .vblank_tick(vblank_tick_b),
    .frame_cnt  (frame_cnt_b)
  );

  wire [43:0] obs_a = {pixel_x_a, pixel_y_a, video_on_a, hsync_n_a, vsync_n_a, vga_rgb_a,
                       vblank_tick_a, frame_cnt_a};
  wire [43:0] obs_b = {pixel_x_b, pixel_y_b, video_on_b, hsync_n_b, vsync_n_b, vga_rgb_b,
                       vblank_tick_b, frame_cnt_b};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got %h expected %h", tag, t, obs, exp);
    end
  endtask

  // Expected outputs after t clock edges since reset release; rgb_prev is the colour that
  // was on pixel_rgb during the previous cycle.
  function automatic logic [43:0] expect_vec(input longint tt, input int hv, input int hfp,
                                             input int hs, input int hbp, input int vv,
                                             input int vfp, input int vs, input int vbp,
                                             input logic [11:0] rgb_prev);
    longint ht, vt, f, x, y, px, py;
    logic von, pvon, hs_n, vs_n, tick;
    logic [11:0] rgb;
    logic [7:0] fc;
    ht   = hv + hfp + hs + hbp;
    vt   = vv + vfp + vs + vbp;
    f    = ht * vt;
    x    = tt % ht;
    y    = (tt / ht) % vt;
    von  = (x < hv) && (y < vv);
    hs_n = 1'b1;
    vs_n = 1'b1;
    rgb  = 12'h000;
    tick = 1'b0;
    fc   = 8'd0;
    if (tt > 0) begin
      px   = (tt - 1) % ht;
      py   = ((tt - 1) / ht) % vt;
      pvon = (px < hv) && (py < vv);
      hs_n = !((px >= hv + hfp) && (px < hv + hfp + hs));
      vs_n = !((py >= vv + vfp) && (py < vv + vfp + vs));
      rgb  = pvon ? rgb_prev : 12'h000;
      tick = ((tt % f) == vv * ht);
    end
    if (tt >= vv * ht) fc = 8'(((tt - vv * ht) / f + 1) % 256);
    return {10'(x), 10'(y), von, hs_n, vs_n, rgb, tick, fc};
  endfunction

  task automatic cycle(input int mode_a);
    check_eq("a_raster", obs_a, expect_vec(t, 640, 16, 96, 48, 480, 10, 2, 33, rgb_a));
    check_eq("b_raster", obs_b, expect_vec(t, BHV, BHFP, BHS, BHBP, BVV, BVFP, BVS, BVBP,
                                           rgb_b));
    if (t < 800 && !hsync_n_a) begin
      hs_low++;
      if (hs_first < 0) hs_first = int'(t);
    end
    if (t < BF) begin
      if (!vsync_n_b) vs_low++;
      if (vblank_tick_b) begin
        ticks_first++;
        tick_first_t = int'(t);
      end
    end
    if (vblank_tick_b) begin
      ticks_b++;
      if (ticks_b == 255) check_eq("b_fc_255", frame_cnt_b, 255);
      if (ticks_b == 256) check_eq("b_fc_wrap", frame_cnt_b, 0);
    end
    case (mode_a)
      0:       rgb_a = 12'hFFF;
      1:       rgb_a = {2'b00, pixel_x_a};
      default: rgb_a = 12'($urandom);
    endcase
    rgb_b = 12'($urandom);
    @(posedge clk);
    t++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("a_in_reset", obs_a, RstVec);
    check_eq("b_in_reset", obs_b, RstVec);
    rst = 1'b0;
    t   = 0;
    #1;
    // Constant white: blanking and video_on edges; 1900 clocks leaves a at (300, 2).
    repeat (1900) cycle(0);
    check_eq("a_hs_low_cnt", hs_low, 96);
    check_eq("a_hs_first", hs_first, 657);
    check_eq("b_vs_low_cnt", vs_low, BVS * BHT);
    check_eq("b_ticks_frame0", ticks_first, 1);
    check_eq("b_tick_pos", tick_first_t, BVV * BHT);
    check_eq("a_pos_pre_rst", {pixel_x_a, pixel_y_a}, {10'd300, 10'd2});

    // Asynchronous reset in the middle of a line, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_eq("a_async_rst", obs_a, RstVec);
    check_eq("b_async_rst", obs_b, RstVec);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("a_rst_hold", obs_a, RstVec);
    rst     = 1'b0;
    t       = 0;
    ticks_b = 0;
    #1;
    for (int i = 0; i < PH2; i++) cycle((i < 1600) ? 1 : 2);
    check_eq("b_tick_total", ticks_b, (PH2 - 1 - BVV * BHT) / BF + 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
